rmii2mii_bridge: RTL and testbench
==================================

RMII2MII_BRIDGE -- requirements
Module: rmii2mii_bridge

Interface
REQ-001 SHALL have parameter DIV10, default 10; clk cycles per dibit in 10 Mb/s mode.
REQ-002 SHALL have parameter CNT_W, default 16; width of rx_frame_cnt.
REQ-003 SHALL have port clk, in, 1; 50 MHz RMII reference clock, the only clock.
REQ-004 SHALL have port resetn, in, 1; asynchronous, active-low reset.
REQ-005 SHALL have port speed_100, in, 1; 1 = 100 Mb/s, 0 = 10 Mb/s.
REQ-006 SHALL have port phy_rxd, in, 2; RMII receive dibit.
REQ-007 SHALL have port phy_crs_dv, in, 1; RMII carrier-sense/data-valid.
REQ-008 SHALL have port mac_rxd, out, 4; MII receive nibble.
REQ-009 SHALL have port mac_rx_dv, out, 1; MII receive data valid.
REQ-010 SHALL have port mac_rx_stb, out, 1; one-cycle pulse marking a new mac_rxd/mac_rx_dv value (replaces RX clock).
REQ-011 SHALL have port mac_crs, out, 1; decoded carrier sense.
REQ-012 SHALL have port mac_txd, in, 4; MII transmit nibble.
REQ-013 SHALL have port mac_tx_en, in, 1; MII transmit enable.
REQ-014 SHALL have port mac_tx_stb, out, 1; one-cycle pulse; MAC SHALL present its next nibble in the same cycle (replaces TX clock).
REQ-015 SHALL have port phy_txd, out, 2; RMII transmit dibit.
REQ-016 SHALL have port phy_tx_en, out, 1; RMII transmit enable.
REQ-017 SHALL have port rx_frame_cnt, out, CNT_W; count of completed frames, wrapping.
REQ-018 SHALL have port rx_false_carrier, out, 1; sticky false-carrier flag, cleared only by reset.

Function
REQ-019 Rate: the dibit strobe SHALL fire every clk at 100 Mb/s and once every DIV10 clks (counter value 0) at 10 Mb/s.
REQ-020 speed_100 SHALL be registered and take effect only while the RX FSM is IDLE and phy_tx_en=0; changes at other times SHALL be deferred.
REQ-021 RX FSM states SHALL be IDLE, PREAMBLE, DATA and FALSE; all transitions occur only on dibit strobes.
REQ-022 IDLE->PREAMBLE SHALL occur on crs_dv=1 with rxd=01; IDLE->FALSE SHALL occur on crs_dv=1 with rxd=10, which also sets rx_false_carrier.
REQ-023 In PREAMBLE, rxd=11 SHALL emit nibble 0xD with dv=1 and enter DATA at dibit phase 0; crs_dv=0 SHALL return to IDLE without asserting dv.
REQ-024 In DATA, the phase-0 dibit SHALL fill nibble[1:0] and the phase-1 dibit nibble[3:2]; the completed nibble SHALL be output with mac_rx_stb one clk after the phase-1 sample.
REQ-025 mac_crs SHALL follow crs_dv sampled at phase 0 only, so that end-of-frame CRS_DV toggling is ignored.
REQ-026 The frame SHALL end when crs_dv=0 at phase 1: dv=0 is output with a final stb, the FSM returns to IDLE, and rx_frame_cnt increments (wrapping at 2^CNT_W).
REQ-027 FALSE SHALL return to IDLE on crs_dv=0; mac_rx_dv SHALL stay 0 throughout.
REQ-028 TX: mac_tx_stb SHALL pulse on every second dibit strobe; mac_txd/mac_tx_en SHALL be captured on the pulse.
REQ-029 phy_txd SHALL carry the captured nibble[1:0] starting the clk after capture, then nibble[3:2] one dibit period later.
REQ-030 phy_tx_en SHALL equal the captured mac_tx_en for both dibits.

Reset
REQ-031 On resetn=0, asynchronously: all outputs 0; FSM IDLE; rate counter 0; speed register 1; rx_frame_cnt 0; sticky flag cleared.
REQ-032 Reset mid-frame SHALL abort the frame without incrementing the count.
REQ-033 The first strobe after reset release SHALL occur at the first clk with counter value 0.

Structure
REQ-034 Package rmii_pkg SHALL hold the RX state enum and the constants PRE_DIBIT=01, SFD_DIBIT=11 and FC_DIBIT=10.
REQ-035 Sub-module rmii_rate_gen SHALL produce the dibit strobe and the deferred speed register.

Verification
REQ-036 At 100M: 28×01, then 01,01,01,11, then 11,00,10,10 with crs_dv=1, then crs_dv=0 -> nibbles 0xD, 0x3, 0xA with dv=1, then dv=0; rx_frame_cnt=1.
REQ-037 At 10M: same frame -> mac_rx_stb spacing of 20 clks; identical nibbles.
REQ-038 CRS_DV toggling 0/1 on phase 0/1 for two nibbles of data -> data preserved, mac_crs=0, dv stays 1 until crs_dv=0 at phase 1.
REQ-039 crs_dv=1 with rxd=10 -> rx_false_carrier=1 and mac_rx_dv never asserted.
REQ-040 TX at 100M: mac_txd=0x9, tx_en=1 on stb -> phy_txd=01 then 10 with phy_tx_en=1; speed_100 toggled mid-frame -> no rate change until idle.
REQ-041 resetn asserted mid-DATA -> outputs 0 asynchronously; rx_frame_cnt unchanged at 0.

Source files
------------

// File: rtl/rmii_pkg.sv
// Shared types and line-code constants for the RMII to MII bridge.
package rmii_pkg;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_DATA     = 2'd2,
    RX_FALSE    = 2'd3
  } rx_state_t;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam logic [1:0] FC_DIBIT  = 2'b10;

endpackage

// File: rtl/rmii2mii_bridge_if.sv
// Link between the dibit rate generator and the RX/TX datapaths of the bridge.
interface rmii2mii_bridge_if;
  logic dibit_stb;
  logic rx_idle;
  logic tx_idle;

  modport master (output dibit_stb, input rx_idle, input tx_idle);
  modport slave  (input dibit_stb, output rx_idle, output tx_idle);
endinterface

// File: rtl/rmii_rate_gen.sv
// Dibit strobe generator with a speed register that only updates while both directions are idle.
module rmii_rate_gen #(
  parameter int DIV10 = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic speed_100,
  rmii2mii_bridge_if.master rate
);

  localparam int CW = (DIV10 > 1) ? $clog2(DIV10) : 1;

  logic [CW-1:0] cnt_q;
  logic          spd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spd_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      if (rate.rx_idle && rate.tx_idle)
        spd_q <= speed_100;
      // down-counter parks at zero in 100M so the first 10M strobe is immediate
      if (spd_q)
        cnt_q <= '0;
      else if (cnt_q == '0)
        cnt_q <= CW'(DIV10 - 1);
      else
        cnt_q <= cnt_q - CW'(1);
    end
  end

  assign rate.dibit_stb = spd_q || (cnt_q == '0);

endmodule

// File: rtl/rmii2mii_bridge.sv
// RMII PHY side to strobe-qualified MII MAC side bridge on the single 50 MHz reference clock.
// state       | meaning
// RX_IDLE     | no carrier, waiting for preamble or false-carrier code
// RX_PREAMBLE | receiving 01 preamble dibits, waiting for the 11 SFD dibit
// RX_DATA     | assembling nibbles from dibit pairs (phase 0 low, phase 1 high)
// RX_FALSE    | false carrier seen, waiting for crs_dv to drop
module rmii2mii_bridge
  import rmii_pkg::*;
#(
  parameter int DIV10 = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             speed_100,
  input  logic [1:0]       phy_rxd,
  input  logic             phy_crs_dv,
  output logic [3:0]       mac_rxd,
  output logic             mac_rx_dv,
  output logic             mac_rx_stb,
  output logic             mac_crs,
  input  logic [3:0]       mac_txd,
  input  logic             mac_tx_en,
  output logic             mac_tx_stb,
  output logic [1:0]       phy_txd,
  output logic             phy_tx_en,
  output logic [CNT_W-1:0] rx_frame_cnt,
  output logic             rx_false_carrier
);

  rmii2mii_bridge_if rate_if ();

  rmii_rate_gen #(.DIV10(DIV10)) u_rate_gen (
    .clk       (clk),
    .resetn    (resetn),
    .speed_100 (speed_100),
    .rate      (rate_if)
  );

  rx_state_t  state_q, state_d;
  logic       stb;
  logic       phase_q;
  logic [1:0] lo_q;
  logic       emit, dv_d, crs_d, frame_end, fc_set;
  logic [3:0] nib_d;
  logic       t_ph_q;
  logic [1:0] tx_hi_q;

  assign stb             = rate_if.dibit_stb;
  assign rate_if.rx_idle = (state_q == RX_IDLE);
  assign rate_if.tx_idle = ~phy_tx_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stb) begin
      case (state_q)
        RX_IDLE:
          if (phy_crs_dv && phy_rxd == PRE_DIBIT)     state_d = RX_PREAMBLE;
          else if (phy_crs_dv && phy_rxd == FC_DIBIT) state_d = RX_FALSE;
        RX_PREAMBLE:
          if (!phy_crs_dv)                state_d = RX_IDLE;
          else if (phy_rxd == SFD_DIBIT)  state_d = RX_DATA;
        RX_DATA:
          if (phase_q && !phy_crs_dv)     state_d = RX_IDLE;
        RX_FALSE:
          if (!phy_crs_dv)                state_d = RX_IDLE;
        default:                          state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    nib_d     = mac_rxd;
    dv_d      = mac_rx_dv;
    crs_d     = mac_crs;
    frame_end = 1'b0;
    fc_set    = 1'b0;
    if (stb) begin
      case (state_q)
        RX_IDLE: begin
          crs_d  = phy_crs_dv;
          fc_set = phy_crs_dv && (phy_rxd == FC_DIBIT);
        end
        RX_PREAMBLE: begin
          crs_d = phy_crs_dv;
          if (phy_crs_dv && phy_rxd == SFD_DIBIT) begin
            emit  = 1'b1;
            nib_d = 4'hD;
            dv_d  = 1'b1;
          end
        end
        RX_DATA: begin
          // crs_dv on the second dibit of a nibble is really data-valid, so CRS ignores it
          if (!phase_q) begin
            crs_d = phy_crs_dv;
          end else if (phy_crs_dv) begin
            emit  = 1'b1;
            nib_d = {phy_rxd, lo_q};
            dv_d  = 1'b1;
          end else begin
            emit      = 1'b1;
            nib_d     = 4'h0;
            dv_d      = 1'b0;
            crs_d     = 1'b0;
            frame_end = 1'b1;
          end
        end
        default: crs_d = phy_crs_dv;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q          <= 1'b0;
      lo_q             <= 2'b00;
      mac_rxd          <= 4'h0;
      mac_rx_dv        <= 1'b0;
      mac_rx_stb       <= 1'b0;
      mac_crs          <= 1'b0;
      rx_frame_cnt     <= '0;
      rx_false_carrier <= 1'b0;
    end else begin
      if (state_q != RX_DATA) phase_q <= 1'b0;
      else if (stb)           phase_q <= ~phase_q;
      if (stb && state_q == RX_DATA && !phase_q) lo_q <= phy_rxd;
      mac_rxd    <= nib_d;
      mac_rx_dv  <= dv_d;
      mac_rx_stb <= emit;
      mac_crs    <= crs_d;
      if (frame_end) rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
      if (fc_set)    rx_false_carrier <= 1'b1;
    end
  end

  // MAC nibble is taken on the strobe that starts a dibit pair
  assign mac_tx_stb = stb && t_ph_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t_ph_q    <= 1'b0;
      tx_hi_q   <= 2'b00;
      phy_txd   <= 2'b00;
      phy_tx_en <= 1'b0;
    end else if (stb) begin
      t_ph_q <= ~t_ph_q;
      if (t_ph_q) begin
        phy_txd   <= mac_txd[1:0];
        tx_hi_q   <= mac_txd[3:2];
        phy_tx_en <= mac_tx_en;
      end else begin
        phy_txd   <= tx_hi_q;
      end
    end
  end

endmodule

// File: tb/tb_rmii2mii_bridge.sv
// Directed bench for rmii2mii_bridge: RX framing at both rates, CRS_DV toggling, false carrier, TX, reset.
module tb_rmii2mii_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        speed_100;
  logic [1:0]  phy_rxd;
  logic        phy_crs_dv;
  logic [3:0]  mac_rxd;
  logic        mac_rx_dv;
  logic        mac_rx_stb;
  logic        mac_crs;
  logic [3:0]  mac_txd;
  logic        mac_tx_en;
  logic        mac_tx_stb;
  logic [1:0]  phy_txd;
  logic        phy_tx_en;
  logic [15:0] rx_frame_cnt;
  logic        rx_false_carrier;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dv_cnt = 0;

  typedef struct {
    logic [3:0] nib;
    logic       dv;
    logic       crs;
    int         cyc;
  } ev_t;
  ev_t evq[$];

  rmii2mii_bridge #(.DIV10(10), .CNT_W(16)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .speed_100        (speed_100),
    .phy_rxd          (phy_rxd),
    .phy_crs_dv       (phy_crs_dv),
    .mac_rxd          (mac_rxd),
    .mac_rx_dv        (mac_rx_dv),
    .mac_rx_stb       (mac_rx_stb),
    .mac_crs          (mac_crs),
    .mac_txd          (mac_txd),
    .mac_tx_en        (mac_tx_en),
    .mac_tx_stb       (mac_tx_stb),
    .phy_txd          (phy_txd),
    .phy_tx_en        (phy_tx_en),
    .rx_frame_cnt     (rx_frame_cnt),
    .rx_false_carrier (rx_false_carrier)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mac_rx_stb) evq.push_back('{mac_rxd, mac_rx_dv, mac_crs, cyc});
    if (mac_rx_dv)  dv_cnt <= dv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dibit(input logic dv, input logic [1:0] d, input int hold);
    phy_crs_dv = dv;
    phy_rxd    = d;
    repeat (hold) @(negedge clk);
  endtask

  task automatic std_frame(input int hold);
    repeat (31) dibit(1'b1, 2'b01, hold);
    dibit(1'b1, 2'b11, hold);
    dibit(1'b1, 2'b11, hold);
    dibit(1'b1, 2'b00, hold);
    dibit(1'b1, 2'b10, hold);
    dibit(1'b1, 2'b10, hold);
    dibit(1'b0, 2'b00, hold);
    dibit(1'b0, 2'b00, hold);
    repeat (3) dibit(1'b0, 2'b00, hold);
  endtask

  int base;
  int d0;
  int c0, c1;

  initial begin
    resetn     = 1'b0;
    speed_100  = 1'b1;
    phy_rxd    = 2'b00;
    phy_crs_dv = 1'b0;
    mac_txd    = 4'h0;
    mac_tx_en  = 1'b0;
    #25;
    chk("rst_rxd",    {28'd0, mac_rxd},      32'h0);
    chk("rst_rx_dv",  {31'd0, mac_rx_dv},    32'h0);
    chk("rst_rx_stb", {31'd0, mac_rx_stb},   32'h0);
    chk("rst_crs",    {31'd0, mac_crs},      32'h0);
    chk("rst_tx_stb", {31'd0, mac_tx_stb},   32'h0);
    chk("rst_phy_txd",{30'd0, phy_txd},      32'h0);
    chk("rst_tx_en",  {31'd0, phy_tx_en},    32'h0);
    chk("rst_cnt",    {16'd0, rx_frame_cnt}, 32'h0);
    chk("rst_fc",     {31'd0, rx_false_carrier}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 100M standard frame
    base = evq.size();
    std_frame(1);
    chk("f100_nev",  evq.size() - base, 4);
    chk("f100_n0",   {28'd0, evq[base].nib},   32'hD);
    chk("f100_dv0",  {31'd0, evq[base].dv},    32'h1);
    chk("f100_n1",   {28'd0, evq[base+1].nib}, 32'h3);
    chk("f100_dv1",  {31'd0, evq[base+1].dv},  32'h1);
    chk("f100_n2",   {28'd0, evq[base+2].nib}, 32'hA);
    chk("f100_dv2",  {31'd0, evq[base+2].dv},  32'h1);
    chk("f100_dv3",  {31'd0, evq[base+3].dv},  32'h0);
    chk("f100_cnt",  {16'd0, rx_frame_cnt},    32'h1);
    chk("f100_crs",  {31'd0, mac_crs},         32'h0);

    // 10M standard frame
    speed_100 = 1'b0;
    repeat (3) @(negedge clk);
    base = evq.size();
    std_frame(10);
    chk("f10_nev",   evq.size() - base, 4);
    chk("f10_n0",    {28'd0, evq[base].nib},   32'hD);
    chk("f10_n1",    {28'd0, evq[base+1].nib}, 32'h3);
    chk("f10_n2",    {28'd0, evq[base+2].nib}, 32'hA);
    chk("f10_dv3",   {31'd0, evq[base+3].dv},  32'h0);
    chk("f10_gap01", evq[base+1].cyc - evq[base].cyc,   20);
    chk("f10_gap12", evq[base+2].cyc - evq[base+1].cyc, 20);
    chk("f10_gap23", evq[base+3].cyc - evq[base+2].cyc, 20);
    chk("f10_cnt",   {16'd0, rx_frame_cnt},    32'h2);

    // 100M frame with CRS_DV toggling on the last two nibbles
    speed_100 = 1'b1;
    repeat (3) @(negedge clk);
    base = evq.size();
    repeat (4) dibit(1'b1, 2'b01, 1);
    dibit(1'b1, 2'b11, 1);
    dibit(1'b1, 2'b10, 1);
    dibit(1'b1, 2'b01, 1);
    dibit(1'b0, 2'b11, 1);
    dibit(1'b1, 2'b00, 1);
    dibit(1'b0, 2'b01, 1);
    dibit(1'b1, 2'b10, 1);
    dibit(1'b0, 2'b00, 1);
    dibit(1'b0, 2'b00, 1);
    repeat (3) dibit(1'b0, 2'b00, 1);
    chk("tog_nev",  evq.size() - base, 5);
    chk("tog_n1",   {28'd0, evq[base+1].nib}, 32'h6);
    chk("tog_crs1", {31'd0, evq[base+1].crs}, 32'h1);
    chk("tog_n2",   {28'd0, evq[base+2].nib}, 32'h3);
    chk("tog_dv2",  {31'd0, evq[base+2].dv},  32'h1);
    chk("tog_crs2", {31'd0, evq[base+2].crs}, 32'h0);
    chk("tog_n3",   {28'd0, evq[base+3].nib}, 32'h9);
    chk("tog_dv3",  {31'd0, evq[base+3].dv},  32'h1);
    chk("tog_crs3", {31'd0, evq[base+3].crs}, 32'h0);
    chk("tog_dv4",  {31'd0, evq[base+4].dv},  32'h0);
    chk("tog_cnt",  {16'd0, rx_frame_cnt},    32'h3);

    // false carrier
    chk("fc_pre", {31'd0, rx_false_carrier}, 32'h0);
    base = evq.size();
    d0   = dv_cnt;
    dibit(1'b1, 2'b10, 1);
    dibit(1'b1, 2'b10, 1);
    dibit(1'b1, 2'b00, 1);
    dibit(1'b1, 2'b01, 1);
    dibit(1'b1, 2'b11, 1);
    repeat (3) dibit(1'b0, 2'b00, 1);
    chk("fc_flag", {31'd0, rx_false_carrier}, 32'h1);
    chk("fc_nev",  evq.size() - base, 0);
    chk("fc_dv",   dv_cnt - d0, 0);
    chk("fc_cnt",  {16'd0, rx_frame_cnt}, 32'h3);

    // TX at 100M with a deferred speed change
    for (int i = 0; i < 10 && !mac_tx_stb; i++) @(negedge clk);
    chk("tx_stb_found", {31'd0, mac_tx_stb}, 32'h1);
    mac_txd = 4'h9; mac_tx_en = 1'b1;
    @(negedge clk);
    chk("tx_d0",    {30'd0, phy_txd},   32'h1);
    chk("tx_en0",   {31'd0, phy_tx_en}, 32'h1);
    @(negedge clk);
    chk("tx_d1",    {30'd0, phy_txd},   32'h2);
    chk("tx_en1",   {31'd0, phy_tx_en}, 32'h1);
    chk("tx_stb2",  {31'd0, mac_tx_stb}, 32'h1);
    speed_100 = 1'b0;
    mac_txd = 4'h6;
    @(negedge clk);
    chk("tx_d2",    {30'd0, phy_txd},   32'h2);
    chk("tx_stb3",  {31'd0, mac_tx_stb}, 32'h0);
    @(negedge clk);
    chk("tx_d3",    {30'd0, phy_txd},   32'h1);
    chk("tx_defer", {31'd0, mac_tx_stb}, 32'h1);
    mac_txd = 4'h0; mac_tx_en = 1'b0;
    @(negedge clk);
    chk("tx_en_off", {31'd0, phy_tx_en}, 32'h0);
    for (int i = 0; i < 40 && !mac_tx_stb; i++) @(negedge clk);
    chk("tx10_stb_a", {31'd0, mac_tx_stb}, 32'h1);
    c0 = cyc;
    @(negedge clk);
    for (int i = 0; i < 40 && !mac_tx_stb; i++) @(negedge clk);
    chk("tx10_stb_b", {31'd0, mac_tx_stb}, 32'h1);
    c1 = cyc;
    chk("tx10_spacing", c1 - c0, 20);

    // reset in the middle of a frame
    speed_100 = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #2;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_cnt0", {16'd0, rx_frame_cnt}, 32'h0);
    repeat (8) dibit(1'b1, 2'b01, 1);
    dibit(1'b1, 2'b11, 1);
    dibit(1'b1, 2'b01, 1);
    chk("mr_dv_pre", {31'd0, mac_rx_dv}, 32'h1);
    #3;
    resetn = 1'b0;
    #1;
    base = evq.size();
    chk("mr_dv",  {31'd0, mac_rx_dv},    32'h0);
    chk("mr_rxd", {28'd0, mac_rxd},      32'h0);
    chk("mr_crs", {31'd0, mac_crs},      32'h0);
    chk("mr_cnt", {16'd0, rx_frame_cnt}, 32'h0);
    @(negedge clk);
    dibit(1'b1, 2'b10, 1);
    resetn = 1'b1;
    dibit(1'b0, 2'b00, 1);
    repeat (5) dibit(1'b0, 2'b00, 1);
    chk("mr_cnt_after", {16'd0, rx_frame_cnt}, 32'h0);
    chk("mr_nev",       evq.size() - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
